// File: rtl/bp_nonsynth_commit_pairer.sv
// bp_nonsynth_commit_pairer: orders committed instructions and pairs each
// register-writing commit with its (possibly late) ird/frd writeback.
//
// Ports:
//   clk_i, reset_n_i          clock, async active-low reset
//   commit_*_i                committed instruction (pc, instr, expects-write flag)
//   ird_* / frd_*             integer / FP register-file writebacks
//   retire_*_o, retire_ready_i ordered retire records on a valid/ready handshake
//   overflow_o, orphan_o, timeout_o  sticky error flags
`timescale 1ns/1ps
module bp_nonsynth_commit_pairer #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int dpath_width_p = 64,
    parameter int els_p         = 8,
    parameter int timeout_p     = 255
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     commit_v_i,
    input  logic [vaddr_width_p-1:0] commit_pc_i,
    input  logic [instr_width_p-1:0] commit_instr_i,
    input  logic                     commit_wb_i,
    input  logic                     ird_w_v_i,
    input  logic [4:0]               ird_addr_i,
    input  logic [dpath_width_p-1:0] ird_data_i,
    input  logic                     frd_w_v_i,
    input  logic [4:0]               frd_addr_i,
    input  logic [dpath_width_p-1:0] frd_data_i,
    output logic                     retire_v_o,
    input  logic                     retire_ready_i,
    output logic [vaddr_width_p-1:0] retire_pc_o,
    output logic [instr_width_p-1:0] retire_instr_o,
    output logic [29:0]              retire_itag_o,
    output logic                     retire_ird_v_o,
    output logic                     retire_frd_v_o,
    output logic [4:0]               retire_rd_addr_o,
    output logic [dpath_width_p-1:0] retire_rd_data_o,
    output logic                     overflow_o,
    output logic                     orphan_o,
    output logic                     timeout_o
);

    localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp  = ptr_w_lp + 1;
    localparam int wait_w_lp = $clog2(timeout_p + 1);

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic                     wb;
        logic [29:0]              itag;
    } cq_entry_t;

    typedef struct packed {
        logic                     is_fp;
        logic [4:0]               addr;
        logic [dpath_width_p-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic                     v;
        logic [vaddr_width_p-1:0] pc;
        logic [instr_width_p-1:0] instr;
        logic [29:0]              itag;
        logic                     ird_v;
        logic                     frd_v;
        logic [4:0]               addr;
        logic [dpath_width_p-1:0] data;
    } ret_t;

    typedef enum logic [1:0] {
        e_idle,
        e_resolve,
        e_wait
    } state_e;

    cq_entry_t             cq_mem_q [els_p];
    cq_entry_t             cq_mem_d [els_p];
    logic [ptr_w_lp-1:0]   cq_rd_q, cq_rd_d, cq_wr_q, cq_wr_d;
    logic [cnt_w_lp-1:0]   cq_cnt_q, cq_cnt_d;
    wb_entry_t             wq_mem_q [els_p];
    wb_entry_t             wq_mem_d [els_p];
    logic [ptr_w_lp-1:0]   wq_rd_q, wq_rd_d, wq_wr_q, wq_wr_d;
    logic [cnt_w_lp-1:0]   wq_cnt_q, wq_cnt_d;
    logic [29:0]           itag_q, itag_d;
    logic [cnt_w_lp-1:0]   pend_q, pend_d;
    logic [wait_w_lp-1:0]  wait_q, wait_d;
    state_e                state_q, state_d;
    ret_t                  ret_q, ret_d;
    logic                  overflow_q, overflow_d;
    logic                  orphan_q, orphan_d;
    logic                  timeout_q, timeout_d;

    logic [cnt_w_lp:0]     occ;
    logic [cnt_w_lp-1:0]   pend_eff;
    logic                  full, cq_push, head_v;
    logic                  any_wb, wb_push, wb_avail;
    logic                  timeout_hit, paired, timed, load;
    cq_entry_t             new_cq, head;
    wb_entry_t             new_wb, wb_head;

    always_comb begin
        // The output register counts toward capacity, so els_p commits
        // may be outstanding before the consumer takes anything.
        occ      = {1'b0, cq_cnt_q} + {{cnt_w_lp{1'b0}}, ret_q.v};
        full     = occ >= (cnt_w_lp+1)'(els_p);
        cq_push  = commit_v_i & ~full;
        new_cq   = '{pc: commit_pc_i, instr: commit_instr_i,
                     wb: commit_wb_i, itag: itag_q};
        // Empty queue: the incoming commit is the head (push+pop cancel).
        head_v   = (cq_cnt_q != '0) | cq_push;
        head     = (cq_cnt_q == '0) ? new_cq : cq_mem_q[cq_rd_q];

        pend_eff = pend_q + cnt_w_lp'(cq_push & commit_wb_i);
        any_wb   = ird_w_v_i | frd_w_v_i;
        wb_push  = any_wb & (pend_eff != '0);
        new_wb   = '{is_fp: ~ird_w_v_i,
                     addr:  ird_w_v_i ? ird_addr_i : frd_addr_i,
                     data:  ird_w_v_i ? ird_data_i : frd_data_i};
        wb_avail = (wq_cnt_q != '0) | wb_push;
        wb_head  = (wq_cnt_q == '0) ? new_wb : wq_mem_q[wq_rd_q];

        timeout_hit = (state_q == e_wait)
                    & (wait_q == wait_w_lp'(timeout_p));
        paired   = head.wb & wb_avail;
        timed    = head.wb & ~wb_avail & timeout_hit;
        load     = head_v & (~head.wb | paired | timed)
                 & (~ret_q.v | retire_ready_i);

        cq_mem_d = cq_mem_q;
        if (cq_push) cq_mem_d[cq_wr_q] = new_cq;
        cq_wr_d  = cq_wr_q + ptr_w_lp'(cq_push);
        cq_rd_d  = cq_rd_q + ptr_w_lp'(load);
        cq_cnt_d = cq_cnt_q + cnt_w_lp'(cq_push) - cnt_w_lp'(load);

        wq_mem_d = wq_mem_q;
        if (wb_push) wq_mem_d[wq_wr_q] = new_wb;
        wq_wr_d  = wq_wr_q + ptr_w_lp'(wb_push);
        wq_rd_d  = wq_rd_q + ptr_w_lp'(load & paired);
        wq_cnt_d = wq_cnt_q + cnt_w_lp'(wb_push)
                 - cnt_w_lp'(load & paired);

        itag_d   = itag_q + 30'(cq_push);
        pend_d   = pend_eff - cnt_w_lp'(wb_push)
                 - cnt_w_lp'(load & timed);

        state_d  = e_idle;
        if (!head_v)                   state_d = e_idle;
        else if (load)                 state_d = (cq_cnt_d != '0) ? e_resolve : e_idle;
        else if (head.wb && !wb_avail) state_d = e_wait;
        else                           state_d = e_resolve;

        // Counter saturates at timeout_p while the output is blocked.
        wait_d = '0;
        if (state_d == e_wait && state_q == e_wait)
            wait_d = timeout_hit ? wait_q : wait_q + 1'b1;

        ret_d = ret_q;
        if (load) begin
            ret_d.v     = 1'b1;
            ret_d.pc    = head.pc;
            ret_d.instr = head.instr;
            ret_d.itag  = head.itag;
            ret_d.ird_v = paired & ~wb_head.is_fp;
            ret_d.frd_v = paired & wb_head.is_fp;
            ret_d.addr  = paired ? wb_head.addr : '0;
            ret_d.data  = paired ? wb_head.data : '0;
        end else if (retire_ready_i) begin
            ret_d.v = 1'b0;
        end

        overflow_d = overflow_q | (commit_v_i & full);
        orphan_d   = orphan_q | (any_wb & (pend_eff == '0))
                   | (ird_w_v_i & frd_w_v_i);
        timeout_d  = timeout_q | (load & timed);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                cq_mem_q[i] <= '0;
                wq_mem_q[i] <= '0;
            end
            cq_rd_q    <= '0;
            cq_wr_q    <= '0;
            cq_cnt_q   <= '0;
            wq_rd_q    <= '0;
            wq_wr_q    <= '0;
            wq_cnt_q   <= '0;
            itag_q     <= '0;
            pend_q     <= '0;
            wait_q     <= '0;
            state_q    <= e_idle;
            ret_q      <= '0;
            overflow_q <= 1'b0;
            orphan_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            cq_mem_q   <= cq_mem_d;
            wq_mem_q   <= wq_mem_d;
            cq_rd_q    <= cq_rd_d;
            cq_wr_q    <= cq_wr_d;
            cq_cnt_q   <= cq_cnt_d;
            wq_rd_q    <= wq_rd_d;
            wq_wr_q    <= wq_wr_d;
            wq_cnt_q   <= wq_cnt_d;
            itag_q     <= itag_d;
            pend_q     <= pend_d;
            wait_q     <= wait_d;
            state_q    <= state_d;
            ret_q      <= ret_d;
            overflow_q <= overflow_d;
            orphan_q   <= orphan_d;
            timeout_q  <= timeout_d;
        end
    end

    assign retire_v_o       = ret_q.v;
    assign retire_pc_o      = ret_q.pc;
    assign retire_instr_o   = ret_q.instr;
    assign retire_itag_o    = ret_q.itag;
    assign retire_ird_v_o   = ret_q.ird_v;
    assign retire_frd_v_o   = ret_q.frd_v;
    assign retire_rd_addr_o = ret_q.addr;
    assign retire_rd_data_o = ret_q.data;
    assign overflow_o       = overflow_q;
    assign orphan_o         = orphan_q;
    assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_bp_nonsynth_commit_pairer.sv
// Bench for bp_nonsynth_commit_pairer: directed vector table, corner
// sequences, and random traffic against an in-order pairing model.
`timescale 1ns/1ps
module tb_bp_nonsynth_commit_pairer;

    localparam int ELS = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        commit_v = 1'b0;
    logic [38:0] commit_pc = '0;
    logic [31:0] commit_instr = '0;
    logic        commit_wb = 1'b0;
    logic        ird_v = 1'b0;
    logic [4:0]  ird_addr = '0;
    logic [63:0] ird_data = '0;
    logic        frd_v = 1'b0;
    logic [4:0]  frd_addr = '0;
    logic [63:0] frd_data = '0;
    logic        ready = 1'b1;
    logic        retire_v_o;
    logic [38:0] retire_pc_o;
    logic [31:0] retire_instr_o;
    logic [29:0] retire_itag_o;
    logic        retire_ird_v_o;
    logic        retire_frd_v_o;
    logic [4:0]  retire_rd_addr_o;
    logic [63:0] retire_rd_data_o;
    logic        overflow_o;
    logic        orphan_o;
    logic        timeout_o;

    bp_nonsynth_commit_pairer dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .commit_v_i(commit_v), .commit_pc_i(commit_pc),
        .commit_instr_i(commit_instr), .commit_wb_i(commit_wb),
        .ird_w_v_i(ird_v), .ird_addr_i(ird_addr), .ird_data_i(ird_data),
        .frd_w_v_i(frd_v), .frd_addr_i(frd_addr), .frd_data_i(frd_data),
        .retire_v_o(retire_v_o), .retire_ready_i(ready),
        .retire_pc_o(retire_pc_o), .retire_instr_o(retire_instr_o),
        .retire_itag_o(retire_itag_o),
        .retire_ird_v_o(retire_ird_v_o), .retire_frd_v_o(retire_frd_v_o),
        .retire_rd_addr_o(retire_rd_addr_o),
        .retire_rd_data_o(retire_rd_data_o),
        .overflow_o(overflow_o), .orphan_o(orphan_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [38:0] pc);
        return pc[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        commit_v = 1'b0;
        commit_wb = 1'b0;
        ird_v = 1'b0;
        frd_v = 1'b0;
    endtask

    task automatic commit(input logic [38:0] pc, input logic wb);
        commit_v = 1'b1;
        commit_pc = pc;
        commit_instr = instr_of(pc);
        commit_wb = wb;
    endtask

    task automatic do_reset();
        idle_in();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_v"}, 64'(retire_v_o), 64'd0);
        chk({tag, "_pc"}, 64'(retire_pc_o), 64'd0);
        chk({tag, "_instr"}, 64'(retire_instr_o), 64'd0);
        chk({tag, "_itag"}, 64'(retire_itag_o), 64'd0);
        chk({tag, "_rdv"}, 64'({retire_ird_v_o, retire_frd_v_o}), 64'd0);
        chk({tag, "_addr"}, 64'(retire_rd_addr_o), 64'd0);
        chk({tag, "_data"}, retire_rd_data_o, 64'd0);
        chk({tag, "_flags"}, 64'({overflow_o, orphan_o, timeout_o}), 64'd0);
    endtask

    typedef struct {
        logic        cv;
        logic        cwb;
        logic [38:0] pc;
        logic        iv;
        logic [4:0]  ia;
        logic [63:0] id;
        logic        fv;
        logic [4:0]  fa;
        logic [63:0] fd;
        logic        ev;
        logic [29:0] eitag;
        logic [38:0] epc;
        logic        eird;
        logic        efrd;
        logic [4:0]  ea;
        logic [63:0] ed;
        logic        eorph;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    // Reference model state for random traffic.
    typedef struct {
        logic [29:0] itag;
        logic [38:0] pc;
        logic        wb;
    } mc_t;
    typedef struct {
        logic        fp;
        logic [4:0]  a;
        logic [63:0] d;
    } mw_t;
    mc_t m_cq [$];
    mw_t m_wq [$];

    task automatic compare_pop();
        mc_t c;
        mw_t w;
        logic pr;
        if (m_cq.size() == 0) begin
            chk("rand_unexpected_record", 64'(retire_v_o), 64'd0);
            return;
        end
        c = m_cq.pop_front();
        w = '{fp: 1'b0, a: 5'd0, d: 64'd0};
        pr = 1'b0;
        if (c.wb) begin
            if (m_wq.size() == 0) begin
                chk("rand_model_wb_missing", 64'd1, 64'd0);
            end else begin
                w = m_wq.pop_front();
                pr = 1'b1;
            end
        end
        chk("rand_itag", 64'(retire_itag_o), 64'(c.itag));
        chk("rand_pc", 64'(retire_pc_o), 64'(c.pc));
        chk("rand_instr", 64'(retire_instr_o), 64'(instr_of(c.pc)));
        chk("rand_rdv", 64'({retire_ird_v_o, retire_frd_v_o}),
            64'({pr & ~w.fp, pr & w.fp}));
        if (pr) begin
            chk("rand_addr", 64'(retire_rd_addr_o), 64'(w.a));
            chk("rand_data", retire_rd_data_o, w.d);
        end
    endtask

    initial begin
        int n;
        int issued, taken, wbc, wbs;
        logic [29:0] nitag;

        tbl[0]  = '{1'b1, 1'b0, 39'h1000, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b1, 30'd0, 39'h1000, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 39'h1004, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b1, 30'd1, 39'h1004, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 39'h1008, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b1, 30'd2, 39'h1008, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 39'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b0, 30'd0, 39'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 39'h80000000, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b0, 30'd0, 39'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0};
        tbl[5]  = tbl[3];
        tbl[6]  = tbl[3];
        tbl[7]  = tbl[3];
        tbl[8]  = '{1'b0, 1'b0, 39'h0, 1'b1, 5'd5, 64'hdead, 1'b0, 5'd0, 64'h0,
                    1'b1, 30'd3, 39'h80000000, 1'b1, 1'b0, 5'd5, 64'hdead, 1'b0};
        tbl[9]  = tbl[3];
        tbl[10] = '{1'b1, 1'b1, 39'h2000, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'h0,
                    1'b1, 30'd4, 39'h2000, 1'b1, 1'b0, 5'd7, 64'h77, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 39'h2004, 1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h33,
                    1'b1, 30'd5, 39'h2004, 1'b0, 1'b1, 5'd3, 64'h33, 1'b0};
        tbl[12] = tbl[3];
        tbl[13] = '{1'b0, 1'b0, 39'h0, 1'b1, 5'd1, 64'h11, 1'b0, 5'd0, 64'h0,
                    1'b0, 30'd0, 39'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 39'h2008, 1'b1, 5'd2, 64'h22, 1'b1, 5'd4, 64'h44,
                    1'b1, 30'd6, 39'h2008, 1'b1, 1'b0, 5'd2, 64'h22, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 39'h0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                    1'b0, 30'd0, 39'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1};

        // Reset state, sampled while reset is held.
        step();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Directed vector table, consumer always ready.
        ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            commit_v = tbl[i].cv;
            commit_wb = tbl[i].cwb;
            commit_pc = tbl[i].pc;
            commit_instr = instr_of(tbl[i].pc);
            ird_v = tbl[i].iv;
            ird_addr = tbl[i].ia;
            ird_data = tbl[i].id;
            frd_v = tbl[i].fv;
            frd_addr = tbl[i].fa;
            frd_data = tbl[i].fd;
            step();
            chk($sformatf("tbl%0d_v", i), 64'(retire_v_o), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_itag", i), 64'(retire_itag_o), 64'(tbl[i].eitag));
                chk($sformatf("tbl%0d_pc", i), 64'(retire_pc_o), 64'(tbl[i].epc));
                chk($sformatf("tbl%0d_instr", i), 64'(retire_instr_o),
                    64'(instr_of(tbl[i].epc)));
                chk($sformatf("tbl%0d_rdv", i),
                    64'({retire_ird_v_o, retire_frd_v_o}),
                    64'({tbl[i].eird, tbl[i].efrd}));
                if (tbl[i].eird | tbl[i].efrd) begin
                    chk($sformatf("tbl%0d_addr", i), 64'(retire_rd_addr_o), 64'(tbl[i].ea));
                    chk($sformatf("tbl%0d_data", i), retire_rd_data_o, tbl[i].ed);
                end
            end
            chk($sformatf("tbl%0d_orphan", i), 64'(orphan_o), 64'(tbl[i].eorph));
        end
        idle_in();

        // Overflow: nine commits with the consumer stalled.
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            commit(39'h3000 + 39'(4 * i), 1'b0);
            step();
        end
        idle_in();
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovf_drain%0d_v", k), 64'(retire_v_o), 64'd1);
            chk($sformatf("ovf_drain%0d_itag", k), 64'(retire_itag_o), 64'(k));
            chk($sformatf("ovf_drain%0d_pc", k), 64'(retire_pc_o),
                64'(39'h3000 + 39'(4 * k)));
            step();
        end
        chk("ovf_ninth_absent", 64'(retire_v_o), 64'd0);
        commit(39'h3100, 1'b0);
        step();
        idle_in();
        chk("ovf_next_itag", 64'(retire_itag_o), 64'd8);
        step();

        // Timeout: writeback never arrives.
        do_reset();
        ready = 1'b1;
        commit(39'h4000, 1'b1);
        step();
        idle_in();
        n = 0;
        while (!retire_v_o && n < 400) begin
            step();
            n++;
        end
        chk("to_bound", 64'(n < 400), 64'd1);
        chk("to_not_early", 64'(n >= 200), 64'd1);
        chk("to_flag", 64'(timeout_o), 64'd1);
        chk("to_rdv", 64'({retire_ird_v_o, retire_frd_v_o}), 64'd0);
        chk("to_itag", 64'(retire_itag_o), 64'd0);
        step();
        commit(39'h4004, 1'b0);
        step();
        idle_in();
        chk("to_next_v", 64'(retire_v_o), 64'd1);
        chk("to_next_itag", 64'(retire_itag_o), 64'd1);
        commit(39'h4008, 1'b1);
        ird_v = 1'b1;
        ird_addr = 5'd9;
        ird_data = 64'h99;
        step();
        idle_in();
        chk("to_pair_itag", 64'(retire_itag_o), 64'd2);
        chk("to_pair_rdv", 64'({retire_ird_v_o, retire_frd_v_o}), 64'b10);
        chk("to_pair_data", retire_rd_data_o, 64'h99);
        chk("to_no_orphan", 64'(orphan_o), 64'd0);
        step();

        // Reset while a record is stalled.
        do_reset();
        ready = 1'b0;
        commit(39'h5000, 1'b0);
        step();
        commit(39'h5004, 1'b0);
        step();
        idle_in();
        chk("rst_pre_v", 64'(retire_v_o), 64'd1);
        #2;
        reset_n = 1'b0;
        step();
        chk_all_zero("rst_mid");
        reset_n = 1'b1;
        ready = 1'b1;
        commit(39'h5008, 1'b0);
        step();
        idle_in();
        chk("rst_post_itag", 64'(retire_itag_o), 64'd0);
        chk("rst_post_pc", 64'(retire_pc_o), 64'(39'h5008));
        step();
        chk("rst_no_replay", 64'(retire_v_o), 64'd0);

        // Random traffic against the in-order pairing model.
        do_reset();
        issued = 0;
        taken = 0;
        wbc = 0;
        wbs = 0;
        nitag = '0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            ready = (cyc >= 2800) ? 1'b1 : ($urandom_range(0, 9) < 7);
            idle_in();
            if (cyc < 2800 && (issued - taken) < ELS && $urandom_range(0, 9) < 6) begin
                commit(39'({$urandom, $urandom}), 1'($urandom_range(0, 1)));
                m_cq.push_back('{itag: nitag, pc: commit_pc, wb: commit_wb});
                nitag = nitag + 30'd1;
                issued++;
                if (commit_wb) wbc++;
            end
            if (retire_v_o && ready) begin
                compare_pop();
                taken++;
            end
            if (wbc > wbs && $urandom_range(0, 1) == 1) begin
                mw_t w;
                w.fp = 1'($urandom_range(0, 1));
                w.a = 5'($urandom_range(0, 31));
                w.d = {$urandom, $urandom};
                if (w.fp) begin
                    frd_v = 1'b1;
                    frd_addr = w.a;
                    frd_data = w.d;
                end else begin
                    ird_v = 1'b1;
                    ird_addr = w.a;
                    ird_data = w.d;
                end
                m_wq.push_back(w);
                wbs++;
            end
            step();
        end
        idle_in();
        chk("rand_drained", 64'(m_cq.size()), 64'd0);
        chk("rand_wb_drained", 64'(m_wq.size()), 64'd0);
        chk("rand_flags", 64'({overflow_o, orphan_o, timeout_o}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
